qam16_slicer: RTL and testbench

//   Downstream decision stage of qam_top. Consumes the demodulated I/Q sample stream
//   (demult_valid/demult_i/demult_q), integrates-and-dumps SYM_LEN samples per symbol
//   and slices the averaged point to a 4-bit Gray-coded QAM-16 symbol.

---
 rtl/qam16_slicer.sv | 160 ++++++++++++++++
 tb/tb_qam16_slicer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_slicer.sv
// qam16_slicer
//   Decision stage behind the QAM demodulator. Each symbol is SYM_LEN consecutive
//   valid samples. The stage sums them and divides the sum by SYM_LEN to get an
//   average. It slices that averaged I/Q point to a Gray-coded QAM-16 symbol. The
//   symbol goes into a small show-ahead FIFO that drives a valid/ready output.
//
// Ports
//   axi_clk       clock, rising edge
//   axi_rstn      asynchronous active-low reset
//   demult_valid  input sample strobe (upstream cannot be stalled)
//   demult_i/q    signed 18-bit I/Q samples
//   align         1-cycle pulse: restart symbol phase (a concurrent sample becomes sample 0)
//   dout_valid    FIFO not empty
//   dout          symbol {I[1:0], Q[1:0]}
//   dout_ready    consumer accept
//   overflow      sticky: a symbol was dropped because the FIFO was full
//   ovf_clr       clears overflow (a drop in the same cycle wins)
module qam16_slicer #(
    parameter int SYM_LEN_LOG2 = 3,
    parameter int THRESH       = 8192,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               axi_clk,
    input  logic               axi_rstn,
    input  logic               demult_valid,
    input  logic signed [17:0] demult_i,
    input  logic signed [17:0] demult_q,
    input  logic               align,
    output logic               dout_valid,
    output logic [3:0]         dout,
    input  logic               dout_ready,
    output logic               overflow,
    input  logic               ovf_clr
);

    localparam int ACC_W = 18 + SYM_LEN_LOG2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic signed [17:0] THR_POS = 18'(THRESH);
    localparam logic signed [17:0] THR_NEG = 18'(-THRESH);

    // ------------------------------------------------------------------
    // Integrate and dump
    // ------------------------------------------------------------------
    logic [SYM_LEN_LOG2-1:0]  cnt;
    logic signed [ACC_W-1:0]  acc_i, acc_q;
    logic signed [ACC_W-1:0]  ext_i, ext_q;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic                     last_sample;

    assign ext_i = {{SYM_LEN_LOG2{demult_i[17]}}, demult_i};
    assign ext_q = {{SYM_LEN_LOG2{demult_q[17]}}, demult_q};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;

    // An align in the same cycle turns the sample into sample 0. That sample
    // therefore never closes a symbol.
    assign last_sample = demult_valid && !align && (cnt == '1);

    // NOTE: registered state uses non-blocking assignments only. Then every
    // always_ff reads the pre-edge values no matter what order the blocks run in.
    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (align) begin
            cnt   <= demult_valid ? SYM_LEN_LOG2'(1) : '0;
            acc_i <= demult_valid ? ext_i : '0;
            acc_q <= demult_valid ? ext_q : '0;
        end else if (demult_valid) begin
            // cnt is exactly SYM_LEN_LOG2 bits wide, so it wraps after SYM_LEN-1 by itself.
            cnt   <= cnt + 1'b1;
            acc_i <= (cnt == '0) ? ext_i : sum_i;
            acc_q <= (cnt == '0) ? ext_q : sum_q;
        end
    end

    // Averaged point. Dropping the low SYM_LEN_LOG2 bits of a two's-complement
    // sum is an arithmetic shift, so the result rounds toward -inf. The sum cannot
    // overflow ACC_W, so the remaining top 18 bits always hold the full average.
    logic signed [17:0] avg_i, avg_q;
    logic               avg_valid;

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            avg_valid <= 1'b0;
            avg_i     <= '0;
            avg_q     <= '0;
        end else begin
            avg_valid <= last_sample;
            if (last_sample) begin
                avg_i <= sum_i[ACC_W-1:SYM_LEN_LOG2];
                avg_q <= sum_q[ACC_W-1:SYM_LEN_LOG2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Slicer: levels -3/-1/+1/+3 Gray-coded as 00/01/11/10
    // ------------------------------------------------------------------
    function automatic logic [1:0] slice(input logic signed [17:0] x);
        if (x < THR_NEG)        return 2'b00;
        else if (x < 18'sd0)    return 2'b01;
        else if (x < THR_POS)   return 2'b11;
        else                    return 2'b10;
    endfunction

    logic [3:0] sym;
    assign sym = {slice(avg_i), slice(avg_q)};

    // ------------------------------------------------------------------
    // Output FIFO (show-ahead). Each pointer carries one extra wrap bit so that
    // the FIFO can tell full from empty.
    // ------------------------------------------------------------------
    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             empty, full, pop, push_ok, drop;

    always_comb begin
        // NOTE: every combinational output gets a default first. Otherwise a path
        // that leaves one unassigned infers a latch.
        empty   = 1'b0;
        full    = 1'b0;
        pop     = 1'b0;
        push_ok = 1'b0;
        drop    = 1'b0;
        empty   = (wr_ptr == rd_ptr);
        full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        pop     = !empty && dout_ready;
        // A pop in the same cycle frees a slot, so the push can still go in.
        push_ok = avg_valid && (!full || pop);
        drop    = avg_valid && full && !pop;
    end

    // NOTE: the storage array has no reset. The pointers alone decide which
    // entries are valid, and dout is forced to zero while the FIFO is empty.
    always_ff @(posedge axi_clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= sym;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign dout_valid = !empty;
    assign dout       = empty ? 4'b0000 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_qam16_slicer.sv
// Directed bench for qam16_slicer with a symbol scoreboard. The stimulus pushes
// the expected symbol for every symbol it sends. The monitor pops and compares an
// expected symbol each time the DUT hands a symbol over on dout.
module tb_qam16_slicer;

    logic        axi_clk = 1'b0;
    logic        axi_rstn;
    logic        demult_valid;
    logic [17:0] demult_i, demult_q;
    logic        align;
    logic        dout_valid;
    logic [3:0]  dout;
    logic        dout_ready;
    logic        overflow;
    logic        ovf_clr;

    qam16_slicer #(
        .SYM_LEN_LOG2(3),
        .THRESH      (8192),
        .FIFO_DEPTH  (4)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_rstn    (axi_rstn),
        .demult_valid(demult_valid),
        .demult_i    (demult_i),
        .demult_q    (demult_q),
        .align       (align),
        .dout_valid  (dout_valid),
        .dout        (dout),
        .dout_ready  (dout_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
    );

    always #5 axi_clk = ~axi_clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    int         si[8];
    int         sq[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decision for one axis. The argument is the sum of 8 samples.
    function automatic logic [1:0] lvl(input int sum);
        int a;
        a = sum >>> 3;
        if (a >= 8192)  return 2'b10;
        if (a >= 0)     return 2'b11;
        if (a >= -8192) return 2'b01;
        return 2'b00;
    endfunction

    // Scoreboard monitor. It samples at the falling edge, away from the active edge.
    always @(negedge axi_clk) begin
        if (axi_rstn === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
            check("sb_expected_available", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_dout", {28'd0, dout}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic set_const(input int i_val, input int q_val);
        for (int k = 0; k < 8; k++) begin
            si[k] = i_val;
            sq[k] = q_val;
        end
    endtask

    // Sends si/sq[0..n-1]. Entry is at posedge+1; the task returns at posedge+1.
    task automatic send_buf(input int n, input int max_gap, input bit expect_it, input bit align_first);
        int s_i = 0;
        int s_q = 0;
        for (int k = 0; k < n; k++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge axi_clk);
                    #1;
                end
            end
            demult_valid = 1'b1;
            demult_i     = 18'(si[k]);
            demult_q     = 18'(sq[k]);
            align        = align_first && (k == 0);
            @(posedge axi_clk);
            #1;
            demult_valid = 1'b0;
            align        = 1'b0;
            s_i += si[k];
            s_q += sq[k];
        end
        if (expect_it) exp_q.push_back({lvl(s_i), lvl(s_q)});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    logic [1:0] thr_bits [6];
    int         thr_vals [6];
    int         sym_i    [5];
    int         sym_q    [5];
    int         t;

    initial begin
        thr_vals = '{8192, 8191, 0, -1, -8192, -8193};
        thr_bits = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
        sym_i    = '{12000, 3000, -3000, -12000, 12000};
        sym_q    = '{12000, -12000, 3000, -3000, 0};

        axi_rstn     = 1'b0;
        demult_valid = 1'b0;
        demult_i     = '0;
        demult_q     = '0;
        align        = 1'b0;
        dout_ready   = 1'b1;
        ovf_clr      = 1'b0;
        #2;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout",       32'(dout),       32'd0);
        check("rst_overflow",   32'(overflow),   32'd0);
        cycles(3);
        axi_rstn = 1'b1;
        cycles(2);

        // Basic symbol: fixed 2-cycle latency and a single-cycle pulse.
        set_const(12000, -3000);
        send_buf(8, 0, 1'b1, 1'b0);
        @(negedge axi_clk);
        check("lat_t1_not_yet", 32'(dout_valid), 32'd0);
        @(negedge axi_clk);
        check("lat_t2_valid", 32'(dout_valid), 32'd1);
        check("basic_dout",   32'(dout),       32'h9);
        @(negedge axi_clk);
        check("pulse_t3_gone", 32'(dout_valid), 32'd0);
        cycles(1);

        // Thresholds on I, Q held at zero.
        for (int k = 0; k < 6; k++) begin
            set_const(thr_vals[k], 0);
            send_buf(8, 0, 1'b0, 1'b0);
            exp_q.push_back({thr_bits[k], 2'b11});
        end
        // The same thresholds on Q, checked against the model.
        for (int k = 0; k < 6; k++) begin
            set_const(0, thr_vals[k]);
            send_buf(8, 0, 1'b1, 1'b0);
        end

        // Rounding toward -inf: I sum -1 gives -1 (not 0). I sum -65537 gives
        // -8193 (not -8192).
        set_const(0, 7);
        si[0] = -1;
        send_buf(8, 0, 1'b0, 1'b0);
        exp_q.push_back(4'b0111);
        set_const(-8192, 0);
        si[5] = -8193;
        send_buf(8, 0, 1'b0, 1'b0);
        exp_q.push_back(4'b0011);

        // Averaging.
        for (int k = 0; k < 8; k++) begin
            si[k] = (k % 2 == 0) ? 16000 : -16000;
            sq[k] = 0;
        end
        send_buf(8, 0, 1'b0, 1'b0);
        exp_q.push_back(4'b1111);
        set_const(131071, -131072);
        send_buf(8, 0, 1'b0, 1'b0);
        exp_q.push_back(4'b1000);

        // Random symbols, sent once back-to-back and once with idle gaps.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 8; k++) begin
                si[k] = int'($urandom_range(0, 262143)) - 131072;
                sq[k] = int'($urandom_range(0, 262143)) - 131072;
            end
            send_buf(8, 0, 1'b1, 1'b0);
            send_buf(8, 3, 1'b1, 1'b0);
        end
        cycles(4);

        // Backpressure: 4 symbols are held and the 5th is dropped.
        dout_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            set_const(sym_i[s], sym_q[s]);
            send_buf(8, 0, s < 4, 1'b0);
            if (s == 3) begin
                cycles(3);
                check("ovf_not_yet", 32'(overflow), 32'd0);
            end
        end
        cycles(3);
        @(negedge axi_clk);
        check("ovf_set",        32'(overflow),   32'd1);
        check("held_valid",     32'(dout_valid), 32'd1);
        check("held_dout",      32'(dout),       32'(exp_q[0]));
        cycles(1);
        dout_ready = 1'b1;
        cycles(6);
        check("drained_valid",  32'(dout_valid),   32'd0);
        check("drained_sb",     32'(exp_q.size()), 32'd0);
        check("ovf_sticky",     32'(overflow),     32'd1);
        ovf_clr = 1'b1;
        cycles(1);
        ovf_clr = 1'b0;
        check("ovf_cleared",    32'(overflow),     32'd0);

        // align after 3 samples discards them; the next dump comes 8 samples later.
        set_const(131071, 131071);
        send_buf(3, 0, 1'b0, 1'b0);
        align = 1'b1;
        cycles(1);
        align = 1'b0;
        set_const(-5000, 9000);
        send_buf(8, 0, 1'b1, 1'b0);
        // align on a valid sample: that sample starts the new symbol.
        set_const(131071, 131071);
        send_buf(5, 0, 1'b0, 1'b0);
        set_const(-20000, -20000);
        send_buf(8, 2, 1'b1, 1'b1);
        cycles(4);

        // Reset mid-symbol with the FIFO full and overflow set.
        dout_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            set_const(sym_i[s], sym_q[s]);
            send_buf(8, 0, 1'b0, 1'b0);
        end
        cycles(3);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        set_const(131071, -131072);
        send_buf(3, 0, 1'b0, 1'b0);
        @(posedge axi_clk);
        #3;
        axi_rstn = 1'b0;
        #1;
        check("async_rst_valid", 32'(dout_valid), 32'd0);
        check("async_rst_ovf",   32'(overflow),   32'd0);
        check("async_rst_dout",  32'(dout),       32'd0);
        @(posedge axi_clk);
        #1;
        axi_rstn   = 1'b1;
        dout_ready = 1'b1;
        cycles(1);
        set_const(-3000, 3000);
        send_buf(8, 0, 1'b1, 1'b0);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge axi_clk);
            t++;
        end
        check("final_sb_drained", 32'(exp_q.size()), 32'd0);
        cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
